// File: rtl/ising_energy_engine_pkg.sv
// Shared types and width helpers for the Ising energy engine.
// Imported by the interface, the column dot-product unit and the top.
package ising_pkg;

    localparam int ISING_SUM_W = 32;

    typedef logic signed [ISING_SUM_W-1:0] ising_sum_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } ising_state_e;

    // One registered beat result: the summed column contributions plus its valid flag.
    typedef struct packed {
        logic       valid;
        ising_sum_t sum;
    } ising_beat_t;

    function automatic int ising_dot_width(input int n, input int w);
        return w + $clog2(n) + 1;
    endfunction

    function automatic int ising_energy_width(input int n, input int w);
        return w + 2 * $clog2(n) + 1;
    endfunction

    function automatic int ising_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ising_energy_engine_if.sv
// Control, J-stream and result signals of the Ising energy engine.
// Optional energy_delta output exists only when ISING_ENERGY_DELTA_EN is defined.
interface ising_energy_engine_if #(
    parameter int VECTOR_SIZE   = 256,
    parameter int J_WIDTH       = 4,
    parameter int COLS_PER_BEAT = 4
);
    import ising_pkg::*;

    localparam int NUM_BEATS    = VECTOR_SIZE / COLS_PER_BEAT;
    localparam int IDX_W        = ising_idx_width(NUM_BEATS);
    localparam int ENERGY_WIDTH = ising_energy_width(VECTOR_SIZE, J_WIDTH);

    logic                                        start;
    logic                                        clear;
    logic [VECTOR_SIZE-1:0]                      sigma;
    logic signed [ENERGY_WIDTH-1:0]              energy_prev;
    logic                                        j_valid;
    logic                                        j_ready;
    logic [VECTOR_SIZE*COLS_PER_BEAT*J_WIDTH-1:0] j_data;
    logic [IDX_W-1:0]                            chunk_idx;
    logic                                        busy;
    logic                                        done;
    logic signed [ENERGY_WIDTH-1:0]              energy;
    logic                                        accept;
`ifdef ISING_ENERGY_DELTA_EN
    logic signed [ENERGY_WIDTH:0]                energy_delta;
`endif

    modport master (
        output start, clear, sigma, energy_prev, j_valid, j_data,
`ifdef ISING_ENERGY_DELTA_EN
        input  energy_delta,
`endif
        input  j_ready, chunk_idx, busy, done, energy, accept
    );

    modport slave (
        input  start, clear, sigma, energy_prev, j_valid, j_data,
`ifdef ISING_ENERGY_DELTA_EN
        output energy_delta,
`endif
        output j_ready, chunk_idx, busy, done, energy, accept
    );

endinterface

// File: rtl/ising_energy_engine_col_dot.sv
// Signed dot product of one J column with the spin vector, then weighted by
// that column's own spin: contrib = s_c * sum_r s_r * J[r][c].
module ising_col_dot import ising_pkg::*; #(
    parameter int VECTOR_SIZE = 256,
    parameter int J_WIDTH     = 4,
    parameter int J_SIGNED    = 0,
    localparam int DOT_W      = ising_dot_width(VECTOR_SIZE, J_WIDTH)
) (
    input  logic [VECTOR_SIZE-1:0]         sigma_i,
    input  logic [VECTOR_SIZE*J_WIDTH-1:0] col_i,
    input  logic                           sigmaCol_i,
    output logic signed [DOT_W-1:0]        contrib_o
);

    localparam logic SIGN_EXT = (J_SIGNED != 0);

    logic signed [DOT_W-1:0] elem;
    logic signed [DOT_W-1:0] dot;

    always_comb begin
        elem = '0;
        dot  = '0;
        for (int r = 0; r < VECTOR_SIZE; r++) begin
            elem = {{(DOT_W-J_WIDTH){SIGN_EXT & col_i[r*J_WIDTH+J_WIDTH-1]}},
                    col_i[r*J_WIDTH +: J_WIDTH]};
            dot  = sigma_i[r] ? (dot + elem) : (dot - elem);
        end
        contrib_o = sigmaCol_i ? dot : -dot;
    end

endmodule

// File: rtl/ising_energy_engine.sv
// Streams J column blocks and accumulates E = sigma^T J sigma.
// Define ISING_ENERGY_DELTA_EN to add the registered energy_delta output.
module ising_energy_engine import ising_pkg::*; #(
    parameter int VECTOR_SIZE   = 256,
    parameter int J_WIDTH       = 4,
    parameter int COLS_PER_BEAT = 4,
    parameter int J_SIGNED      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ising_energy_engine_if.slave  eng
);

    localparam int NUM_BEATS = VECTOR_SIZE / COLS_PER_BEAT;
    localparam int IDX_W     = ising_idx_width(NUM_BEATS);
    localparam int SIG_W     = ising_idx_width(VECTOR_SIZE);
    localparam int DOT_W     = ising_dot_width(VECTOR_SIZE, J_WIDTH);
    localparam int EW        = ising_energy_width(VECTOR_SIZE, J_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    ising_state_e              state_q;
    logic [IDX_W-1:0]          chunk_q;
    logic [VECTOR_SIZE-1:0]    sigma_q;
    logic signed [EW-1:0]      energyPrev_q;
    ising_beat_t               pipe_q;
    ising_sum_t                acc_q;
    logic                      jReady_q;
    logic                      busy_q;
    logic                      done_q;
    logic signed [EW-1:0]      energy_q;
    logic                      accept_q;

    logic [COLS_PER_BEAT-1:0][DOT_W-1:0] contrib;
    logic [SIG_W-1:0]                    colBase;
    ising_sum_t                          beatSum;
    logic                                fire;

    assign fire    = eng.j_valid && jReady_q;
    assign colBase = SIG_W'(chunk_q) * SIG_W'(COLS_PER_BEAT);

    for (genvar k = 0; k < COLS_PER_BEAT; k++) begin : g_col
        logic [VECTOR_SIZE*J_WIDTH-1:0] col;
        for (genvar r = 0; r < VECTOR_SIZE; r++) begin : g_row
            assign col[r*J_WIDTH +: J_WIDTH] =
                eng.j_data[(r*COLS_PER_BEAT+k)*J_WIDTH +: J_WIDTH];
        end
        ising_col_dot #(
            .VECTOR_SIZE (VECTOR_SIZE),
            .J_WIDTH     (J_WIDTH),
            .J_SIGNED    (J_SIGNED)
        ) u_dot (
            .sigma_i    (sigma_q),
            .col_i      (col),
            .sigmaCol_i (sigma_q[colBase + SIG_W'(k)]),
            .contrib_o  (contrib[k])
        );
    end

    always_comb begin
        beatSum = '0;
        for (int k = 0; k < COLS_PER_BEAT; k++) begin
            beatSum = beatSum + ising_sum_t'($signed(contrib[k]));
        end
    end

`ifdef ISING_ENERGY_DELTA_EN
    logic signed [EW:0] energyDelta_d;
    logic signed [EW:0] energyDelta_q;

    assign energyDelta_d    = {acc_q[EW-1], acc_q[EW-1:0]} - {energyPrev_q[EW-1], energyPrev_q};
    assign eng.energy_delta = energyDelta_q;
`endif

    // Beat sums lag the handshake by one cycle, so DRAIN exists only to fold in the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            chunk_q      <= '0;
            sigma_q      <= '0;
            energyPrev_q <= '0;
            pipe_q       <= '0;
            acc_q        <= '0;
            jReady_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            energy_q     <= '0;
            accept_q     <= 1'b0;
`ifdef ISING_ENERGY_DELTA_EN
            energyDelta_q <= '0;
`endif
        end else begin
            done_q       <= 1'b0;
            pipe_q.valid <= fire;
            pipe_q.sum   <= beatSum;
            if (pipe_q.valid) begin
                acc_q <= acc_q + $signed(pipe_q.sum);
            end
            if (eng.clear) begin
                state_q      <= ST_IDLE;
                chunk_q      <= '0;
                jReady_q     <= 1'b0;
                busy_q       <= 1'b0;
                pipe_q.valid <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (eng.start) begin
                            sigma_q      <= eng.sigma;
                            energyPrev_q <= eng.energy_prev;
                            acc_q        <= '0;
                            chunk_q      <= '0;
                            jReady_q     <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (fire) begin
                            if (chunk_q == LAST_IDX) begin
                                chunk_q  <= '0;
                                jReady_q <= 1'b0;
                                state_q  <= ST_DRAIN;
                            end else begin
                                chunk_q <= chunk_q + IDX_W'(1);
                            end
                        end
                    end
                    ST_DRAIN: begin
                        state_q <= ST_DONE;
                    end
                    ST_DONE: begin
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        energy_q <= acc_q[EW-1:0];
`ifdef ISING_ENERGY_DELTA_EN
                        energyDelta_q <= energyDelta_d;
                        accept_q      <= energyDelta_d[EW];
`else
                        accept_q      <= (acc_q < ising_sum_t'(energyPrev_q));
`endif
                        state_q  <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign eng.j_ready   = jReady_q;
    assign eng.chunk_idx = chunk_q;
    assign eng.busy      = busy_q;
    assign eng.done      = done_q;
    assign eng.energy    = energy_q;
    assign eng.accept    = accept_q;

endmodule

// File: tb/tb_ising_energy_engine.sv
// Directed bench for ising_energy_engine: one unsigned-J and one signed-J
// instance share the same stimulus; expected energies come from hand values or a full model.
module tb_ising_energy_engine;

    localparam int N    = 256;
    localparam int W    = 4;
    localparam int CPB  = 4;
    localparam int NB   = N / CPB;
    localparam int EW   = 21;
    localparam int MAXC = 400;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 clear;
    logic                 j_valid;
    logic [N-1:0]         sigma;
    logic signed [EW-1:0] energy_prev;
    logic [N*CPB*W-1:0]   j_data;

    int  testsRun    = 0;
    int  testsFailed = 0;
    int  tbBeats     = 0;
    bit  hsNow;
    logic [W-1:0] jMat [N][N];

    always #5 clk = ~clk;

    ising_energy_engine_if #(.VECTOR_SIZE(N), .J_WIDTH(W), .COLS_PER_BEAT(CPB)) ifU ();
    ising_energy_engine_if #(.VECTOR_SIZE(N), .J_WIDTH(W), .COLS_PER_BEAT(CPB)) ifS ();

    assign ifU.start = start;        assign ifS.start = start;
    assign ifU.clear = clear;        assign ifS.clear = clear;
    assign ifU.sigma = sigma;        assign ifS.sigma = sigma;
    assign ifU.energy_prev = energy_prev;  assign ifS.energy_prev = energy_prev;
    assign ifU.j_valid = j_valid;    assign ifS.j_valid = j_valid;
    assign ifU.j_data = j_data;      assign ifS.j_data = j_data;

    ising_energy_engine #(.VECTOR_SIZE(N), .J_WIDTH(W), .COLS_PER_BEAT(CPB), .J_SIGNED(0)) dutU (
        .clk   (clk),
        .rst_n (rst_n),
        .eng   (ifU)
    );

    ising_energy_engine #(.VECTOR_SIZE(N), .J_WIDTH(W), .COLS_PER_BEAT(CPB), .J_SIGNED(1)) dutS (
        .clk   (clk),
        .rst_n (rst_n),
        .eng   (ifS)
    );

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fillJ(input bit rnd, input logic [W-1:0] val);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                jMat[r][c] = rnd ? W'($urandom_range(0, 15)) : val;
    endtask

    task automatic packBeat(input int chunk);
        for (int r = 0; r < N; r++)
            for (int k = 0; k < CPB; k++)
                j_data[(r*CPB+k)*W +: W] = jMat[r][chunk*CPB+k];
    endtask

    function automatic longint model(input logic [N-1:0] sg, input bit signedJ);
        longint e = 0;
        longint v;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                v = signedJ ? longint'($signed(jMat[r][c])) : longint'(jMat[r][c]);
                e += ((sg[r] == sg[c]) ? v : -v);
            end
        return e;
    endfunction

    // Assumes caller sits at a falling edge; leaves it at the next falling edge.
    task automatic launch(input logic [N-1:0] sg, input logic signed [EW-1:0] prev);
        sigma       = sg;
        energy_prev = prev;
        start       = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        tbBeats = 0;
        @(negedge clk);
    endtask

    task automatic stepCycle(input bit randValid);
        j_valid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
        packBeat(tbBeats % NB);
        hsNow = j_valid && ifU.j_ready;
        @(posedge clk); #1;
        if (hsNow) tbBeats++;
    endtask

    task automatic applyStimulus(input logic [N-1:0] sg, input logic signed [EW-1:0] prev,
                                 input bit randValid, input int startA, input int startB,
                                 output int doneCycle);
        launch(sg, prev);
        checkOutput("busy_after_start", ifU.busy, 1);
        doneCycle = 0;
        for (int c = 1; c <= MAXC && doneCycle == 0; c++) begin
            start = (c == startA) || (c == startB);
            stepCycle(randValid);
            checkOutput("chunk_idx", ifU.chunk_idx, tbBeats % NB);
            if (ifU.done === 1'b1) doneCycle = c;
            @(negedge clk);
        end
        start   = 1'b0;
        j_valid = 1'b0;
        checkOutput("done_seen", doneCycle != 0, 1);
    endtask

    initial begin
        int           dc;
        int           doneCount;
        longint       expU;
        longint       expS;
        logic [N-1:0] sg;

        rst_n = 1'b1; start = 1'b0; clear = 1'b0; j_valid = 1'b0;
        sigma = '0; energy_prev = '0; j_data = '0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_busy", ifU.busy, 0);
        checkOutput("reset_done", ifU.done, 0);
        checkOutput("reset_j_ready", ifU.j_ready, 0);
        checkOutput("reset_energy", ifU.energy, 0);
        checkOutput("reset_accept", ifU.accept, 0);
        checkOutput("reset_chunk_idx", ifU.chunk_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] J=1, sigma all ones");
        fillJ(0, 4'd1);
        applyStimulus({N{1'b1}}, 0, 0, -1, -1, dc);
        checkOutput("latency_ones", dc, 66);
        checkOutput("energy_ones", ifU.energy, 65536);
        checkOutput("accept_ones", ifU.accept, 0);
        @(posedge clk); #1;
        checkOutput("done_pulse_width", ifU.done, 0);
        checkOutput("busy_after_done", ifU.busy, 0);
        @(negedge clk);

        $display("[TB] J=1, sigma all zeros");
        applyStimulus({N{1'b0}}, 70000, 0, -1, -1, dc);
        checkOutput("energy_zeros", ifU.energy, 65536);
        checkOutput("accept_zeros", ifU.accept, 1);

        $display("[TB] J=1, alternating sigma, energy equal to reference");
        applyStimulus({(N/2){2'b10}}, 0, 0, -1, -1, dc);
        checkOutput("energy_alt", ifU.energy, 0);
        checkOutput("accept_equal", ifU.accept, 0);

        $display("[TB] J=15, sigma all ones");
        fillJ(0, 4'd15);
        applyStimulus({N{1'b1}}, 983041, 0, -1, -1, dc);
        checkOutput("energy_max", ifU.energy, 983040);
        checkOutput("accept_max", ifU.accept, 1);

        $display("[TB] J=4'b1000 on both instances");
        fillJ(0, 4'b1000);
        applyStimulus({N{1'b1}}, 0, 0, -1, -1, dc);
        checkOutput("energy_signed_neg", ifS.energy, -524288);
        checkOutput("accept_signed_neg", ifS.accept, 1);
        checkOutput("energy_unsigned_8", ifU.energy, 524288);
        checkOutput("accept_unsigned_8", ifU.accept, 0);

        $display("[TB] random J and sigma with random j_valid");
        fillJ(1, '0);
        for (int i = 0; i < N / 32; i++) sg[i*32 +: 32] = $urandom;
        expU = model(sg, 0);
        expS = model(sg, 1);
        applyStimulus(sg, EW'(expU), 1, -1, -1, dc);
        checkOutput("energy_rand_u", ifU.energy, expU);
        checkOutput("accept_rand_u", ifU.accept, 0);
        checkOutput("energy_rand_s", ifS.energy, expS);
        checkOutput("accept_rand_s", ifS.accept, (expS < expU) ? 1 : 0);

        $display("[TB] clear after beat 10");
        fillJ(0, 4'd1);
        launch({N{1'b1}}, 0);
        for (int i = 0; i < 10; i++) begin
            stepCycle(0);
            @(negedge clk);
        end
        checkOutput("chunk_before_clear", ifU.chunk_idx, 10);
        clear = 1'b1;
        stepCycle(0);
        clear = 1'b0;
        checkOutput("clear_busy", ifU.busy, 0);
        checkOutput("clear_j_ready", ifU.j_ready, 0);
        checkOutput("clear_done", ifU.done, 0);
        @(negedge clk);
        doneCount = 0;
        for (int i = 0; i < 80; i++) begin
            j_valid = 1'b1;
            @(posedge clk); #1;
            if (ifU.done === 1'b1) doneCount++;
            @(negedge clk);
        end
        j_valid = 1'b0;
        checkOutput("no_done_after_clear", doneCount, 0);
        checkOutput("energy_held", ifU.energy, expU);
        checkOutput("accept_held", ifU.accept, 0);
        applyStimulus({N{1'b1}}, 0, 0, -1, -1, dc);
        checkOutput("latency_after_clear", dc, 66);
        checkOutput("energy_after_clear", ifU.energy, 65536);

        $display("[TB] start while busy and in the DONE cycle");
        applyStimulus({N{1'b0}}, 0, 0, 30, 66, dc);
        checkOutput("latency_restart", dc, 66);
        checkOutput("energy_restart", ifU.energy, 65536);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("no_second_run", ifU.busy, 0);
            @(negedge clk);
        end

        $display("[TB] start and clear together in IDLE");
        start = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b0;
        checkOutput("start_clear_busy", ifU.busy, 0);
        checkOutput("start_clear_j_ready", ifU.j_ready, 0);
        @(posedge clk); #1;
        checkOutput("start_clear_idle", ifU.busy, 0);
        @(negedge clk);

        $display("[TB] reset asserted mid-run");
        launch({N{1'b1}}, 0);
        for (int i = 0; i < 20; i++) begin
            stepCycle(0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", ifU.busy, 0);
        checkOutput("midreset_j_ready", ifU.j_ready, 0);
        checkOutput("midreset_energy", ifU.energy, 0);
        checkOutput("midreset_chunk_idx", ifU.chunk_idx, 0);
        checkOutput("midreset_done", ifU.done, 0);
        checkOutput("midreset_accept", ifU.accept, 0);
        j_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_idle", ifU.busy, 0);
        @(negedge clk);
        applyStimulus({(N/2){2'b01}}, 1, 0, -1, -1, dc);
        checkOutput("latency_post_reset", dc, 66);
        checkOutput("energy_post_reset", ifU.energy, 0);
        checkOutput("accept_post_reset", ifU.accept, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ising_energy_engine.md
Name: ising_energy_engine

Overview:
Streams a VECTOR_SIZE x VECTOR_SIZE coupling matrix J column-block by column-block and computes the Ising energy E = sigma^T J sigma, with sigma in {+1,-1} encoded as 1/0.
- Successor to the fixed-width energy MatMul: adds a valid/ready J stream, signed or unsigned J, and a configurable number of columns per beat.
- Adds a synchronous abort, a done pulse, and an accept flag against the previous energy.
- Sits between the J memory reader and the annealing controller.

Parameters:
- VECTOR_SIZE, 256, spin count; power of two.
- J_WIDTH, 4, bits per J element.
- COLS_PER_BEAT, 4, J columns delivered per handshake; must divide VECTOR_SIZE.
- J_SIGNED, 0, 1 = J elements are two's complement; 0 = unsigned.
- NUM_BEATS, VECTOR_SIZE/COLS_PER_BEAT, derived; not overridable.
- ENERGY_WIDTH, J_WIDTH+2*$clog2(VECTOR_SIZE)+1, signed energy width (21 by default).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a computation; honoured only in IDLE.
- clear  in  1  synchronous abort back to IDLE.
- sigma  in  VECTOR_SIZE  spin vector; 1 = +1, 0 = -1; sampled on accepted start.
- energy_prev  in  ENERGY_WIDTH  signed reference energy; sampled on accepted start.
- j_valid  in  1  j_data valid.
- j_ready  out  1  engine can accept a beat.
- j_data  in  VECTOR_SIZE*COLS_PER_BEAT*J_WIDTH  element (r,k) at bits [(r*COLS_PER_BEAT+k)*J_WIDTH +: J_WIDTH]; column = chunk_idx*COLS_PER_BEAT+k.
- chunk_idx  out  $clog2(NUM_BEATS)  index of the next beat expected (memory address hint).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse; energy/accept valid.
- energy  out  ENERGY_WIDTH  signed result; holds until next done.
- accept  out  1  energy < energy_prev (signed); holds with energy.

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE.
  - j_ready, busy, done, accept = 0.
  - energy = 0.
  - chunk_idx = 0.
  - accumulator and pipeline register = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches sigma and energy_prev, clears the accumulator and chunk_idx, and moves to RUN.
  - busy rises in the next cycle.
- RUN:
  - j_ready=1.
  - A beat is consumed only on j_valid&&j_ready. j_valid low stalls; there is no timeout.
  - Per beat, for each k: dot_k = sum over r of (sigma[r] ? +J[r][c] : -J[r][c]); contrib_k = sigma[c] ? dot_k : -dot_k.
  - beat_sum = sum of contrib_k, registered into pipe_reg in the cycle after the handshake; a valid bit travels with it.
  - The accumulator adds pipe_reg when that valid bit is set.
  - chunk_idx increments on each handshake.
  - When the handshake carries chunk_idx == NUM_BEATS-1: go to DRAIN, j_ready drops the following cycle, and chunk_idx wraps to 0.
- DRAIN: one cycle so the last pipe_reg is added; then go to DONE.
- DONE:
  - One cycle with done=1; energy = accumulator; accept = (accumulator < energy_prev latched).
  - busy=0 in the same cycle; return to IDLE.
- Latency: done is asserted 2 cycles after the last handshake edge. Total = NUM_BEATS + 2 cycles with no stalls.
- Arithmetic:
  - All intermediates are signed and sized so they cannot overflow: dot width J_WIDTH+$clog2(VECTOR_SIZE)+1, beat_sum adds $clog2(COLS_PER_BEAT).
  - Unsigned J is zero-extended; with J_SIGNED=1 it is sign-extended.
- Boundary conditions:
  - start while busy: ignored.
  - start and clear in the same IDLE cycle: clear wins, and the engine stays in IDLE.
  - clear in any state: next cycle IDLE, j_ready=0, busy=0, no done; energy/accept keep their prior values.
  - rst_n low mid-run: all state resets immediately.
  - j_valid while not in RUN: ignored.
  - start in the DONE cycle: ignored; the engine must see it again in IDLE.

Optional Feature:
- Macro ISING_ENERGY_DELTA_EN.
- When defined: extra output energy_delta [ENERGY_WIDTH+1] = energy - energy_prev (signed), registered with done. accept is then derived from its sign bit.
- When undefined: the port and logic are absent, and accept uses a direct signed compare.

Decomposition:
- Package ising_pkg holds:
  - the functions ising_energy_width(N,W) and ising_dot_width(N,W);
  - a typedef enum for the FSM states;
  - a typedef for the per-beat column result.
- One sub-module, ising_col_dot: combinational signed dot of one J column with sigma, instantiated COLS_PER_BEAT times.

Test Plan:
- VECTOR_SIZE=256, unsigned J all 1, sigma all 1, j_valid always 1 -> done at cycle 66 after the start edge, energy=65536.
- Same J, sigma all 0 -> energy=65536. sigma alternating 1010... -> energy=0.
- Unsigned J all 15, sigma all 1 -> energy=983040. J_SIGNED=1, J all 4'b1000 (-8), sigma all 1 -> energy=-524288; with energy_prev=0, accept=1.
- Random J, random sigma, j_valid randomly toggled (50% duty) -> energy matches the golden model, and chunk_idx advances only on handshakes.
- clear pulsed after beat 10 -> busy=0 and no done. A new start then completes correctly, and the previous energy is held until then.
- start pulsed while busy, and rst_n asserted mid-run -> no second run; reset outputs all 0 within the reset cycle.
